div_seq_ctrl: RTL

Multi-cycle sequential unsigned divider with a start/done handshake. It replaces the single-cycle combinational divider on timing-critical paths. An FSM runs a restoring shift-subtract datapath for one quotient bit per clock. It also reports divide-by-zero and holds the results until the next operation is accepted.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/div_seq_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// counter sizing and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DIV_N_DEFAULT = 8;
  localparam int unsigned CNT_W         = cnt_width(DIV_N_DEFAULT);

  // Quotient reported for a zero divisor is this bit replicated N times.
  localparam logic DBZ_Q_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   rem,
  input  logic         qmsb,
  input  logic [N-1:0] b,
  output logic [N:0]   rem_next,
  output logic         qbit
);

  logic [N:0] t;
  logic [N:0] b_ext;
  logic       unused_rem_msb;

  // The restored remainder is always below the divisor, so its top bit is zero.
  assign unused_rem_msb = rem[N];

  assign t        = {rem[N-1:0], qmsb};
  assign b_ext    = {1'b0, b};
  assign qbit     = (t >= b_ext);
  assign rem_next = qbit ? (t - b_ext) : t;

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned divider with start/done handshake; one quotient bit per
// clock, results held until the next accepted request.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_width(N);

  state_e            state_q;
  logic [N-1:0]      qsh_q;
  logic [N-1:0]      dvsr_q;
  logic [N:0]        rem_q;
  logic [CntW-1:0]   cnt_q;
  logic [N:0]        rem_next;
  logic              qbit;

  div_step #(
    .N(N)
  ) u_step (
    .rem     (rem_q),
    .qmsb    (qsh_q[N-1]),
    .b       (dvsr_q),
    .rem_next(rem_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      qsh_q       <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            qsh_q  <= A;
            dvsr_q <= B;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (B != '0) begin
              state_q <= ST_RUN;
              busy    <= 1'b1;
            end else begin
              state_q     <= ST_DONE;
              done        <= 1'b1;
              Q           <= {N{DBZ_Q_BIT}};
              R           <= A;
              div_by_zero <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          qsh_q <= {qsh_q[N-2:0], qbit};
          rem_q <= rem_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            state_q     <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            Q           <= {qsh_q[N-2:0], qbit};
            R           <= rem_next[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
